// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: rotating-priority grant held until done or abandon.
// Optional ARB_HOLD_TIMEOUT_EN adds a MAX_HOLD watchdog and sticky timeout_o.
module rr_bus_arbiter #(
  parameter int NUM_REQ  = 32,
  parameter int ID_W     = 5,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               valid_o,
`ifdef ARB_HOLD_TIMEOUT_EN
  output logic               timeout_o,
`endif
  output logic [ID_W-1:0]    ptr_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               r_state, w_state_d;
  logic [NUM_REQ-1:0]   r_grant, w_grant_d;
  logic [ID_W-1:0]      r_gid, w_gid_d;
  logic                 r_valid, w_valid_d;
  logic [ID_W-1:0]      r_ptr, w_ptr_d;
  logic                 w_any;
  logic [ID_W-1:0]      w_win;
  logic [ID_W-1:0]      w_win_nxt;
  logic                 w_rel;
  logic                 w_to;

  // Scan from ptr upward with wrap; first hit is the winner.
  always_comb begin
    int v_idx;
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_any && req_i[ID_W'(v_idx)]) begin
        w_any = 1'b1;
        w_win = ID_W'(v_idx);
      end
    end
  end

  assign w_win_nxt = (w_win == ID_W'(NUM_REQ - 1))
                   ? '0 : w_win + 1'b1;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold, w_hold_d;
  logic              r_tmo;

  assign w_to = (r_state == BUSY)
             && (r_hold == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    w_hold_d = r_hold;
    if (r_state == IDLE) w_hold_d = '0;
    else if (!w_rel)     w_hold_d = r_hold + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_hold <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_hold <= w_hold_d;
      if (w_to && !done_i && req_i[r_gid]) r_tmo <= 1'b1;
    end
  end

  assign timeout_o = r_tmo;
`else
  assign w_to = 1'b0;
`endif

  assign w_rel = done_i || !req_i[r_gid] || w_to;

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_gid_d   = r_gid;
    w_valid_d = r_valid;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_d        = '0;
          w_grant_d[w_win] = 1'b1;
          w_gid_d          = w_win;
          w_valid_d        = 1'b1;
          w_ptr_d          = w_win_nxt;
          w_state_d        = BUSY;
        end
      end
      BUSY: begin
        if (w_rel) begin
          w_grant_d = '0;
          w_valid_d = 1'b0;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gid   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_gid   <= w_gid_d;
      r_valid <= w_valid_d;
      r_ptr   <= w_ptr_d;
    end
  end

  assign grant_o    = r_grant;
  assign grant_id_o = r_gid;
  assign valid_o    = r_valid;
  assign ptr_o      = r_ptr;

endmodule
